// File: rtl/div16x8.sv
// Sequential 16/8 restoring divider, one quotient bit per clock, signed or unsigned.
// Produces an 8-bit quotient, 8-bit remainder and an {N,Z,V,C} nibble for the CCR merge.
module div16x8 (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        start_in,
    input  logic        signed_in,
    input  logic [15:0] dividend_in,
    input  logic [7:0]  divisor_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        dz_out,
    output logic [7:0]  q_out,
    output logic [7:0]  r_out,
    output logic [3:0]  ccr_out
);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DZ} state_t;

    state_t      state_reg;
    logic [15:0] dvd_reg;
    logic [7:0]  dvs_reg;
    logic [15:0] quo_reg;
    logic [7:0]  rem_reg;
    logic [3:0]  count_reg;
    logic        sign_q_reg;
    logic        sign_r_reg;
    logic        signed_reg;

    logic        dvd_neg;
    logic        dvs_neg;
    logic [15:0] dvd_mag;
    logic [7:0]  dvs_mag;
    logic [8:0]  rem_shift;
    logic        trial_ok;
    logic [7:0]  trial_diff;
    logic [7:0]  q_fix;
    logic [7:0]  r_fix;
    logic        ovf;

    assign dvd_neg = signed_in & dividend_in[15];
    assign dvs_neg = signed_in & divisor_in[7];
    // 0x8000 and 0x80 negate to themselves, which read as the correct unsigned magnitudes
    assign dvd_mag = dvd_neg ? (16'd0 - dividend_in) : dividend_in;
    assign dvs_mag = dvs_neg ? (8'd0 - divisor_in) : divisor_in;

    // The partial remainder is always below the divisor, so 8 stored bits suffice;
    // the transient ninth bit only exists in the shifted trial value.
    assign rem_shift  = {rem_reg, dvd_reg[15]};
    assign trial_ok   = (rem_shift >= {1'b0, dvs_reg});
    assign trial_diff = rem_shift[7:0] - dvs_reg;

    assign q_fix = sign_q_reg ? (8'd0 - quo_reg[7:0]) : quo_reg[7:0];
    assign r_fix = sign_r_reg ? (8'd0 - rem_reg) : rem_reg;

    always_comb begin
        ovf = 1'b0;
        if (signed_reg)
            ovf = sign_q_reg ? (quo_reg > 16'd128) : (quo_reg > 16'd127);
        else
            ovf = (quo_reg > 16'd255);
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_reg  <= IDLE;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
            count_reg  <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            signed_reg <= 1'b0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            dz_out     <= 1'b0;
            q_out      <= '0;
            r_out      <= '0;
            ccr_out    <= '0;
        end else begin
            done_out <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_in) begin
                        dvd_reg    <= dvd_mag;
                        dvs_reg    <= dvs_mag;
                        sign_q_reg <= dvd_neg ^ dvs_neg;
                        sign_r_reg <= dvd_neg;
                        signed_reg <= signed_in;
                        quo_reg    <= '0;
                        rem_reg    <= '0;
                        count_reg  <= '0;
                        busy_out   <= 1'b1;
                        state_reg  <= (divisor_in == 8'd0) ? DZ : ITER;
                    end
                end
                ITER: begin
                    dvd_reg   <= {dvd_reg[14:0], 1'b0};
                    rem_reg   <= trial_ok ? trial_diff : rem_shift[7:0];
                    quo_reg   <= {quo_reg[14:0], trial_ok};
                    count_reg <= count_reg + 4'd1;
                    if (count_reg == 4'd15)
                        state_reg <= FIX;
                end
                FIX: begin
                    q_out     <= q_fix;
                    r_out     <= r_fix;
                    dz_out    <= 1'b0;
                    ccr_out   <= {q_fix[7], (q_fix == 8'd0), ovf, q_fix[0]};
                    done_out  <= 1'b1;
                    busy_out  <= 1'b0;
                    state_reg <= IDLE;
                end
                DZ: begin
                    dz_out    <= 1'b1;
                    done_out  <= 1'b1;
                    busy_out  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div16x8.sv
// Scoreboard bench for div16x8: the driver queues hand-computed results, a negedge
// monitor pops and compares them whenever done_out pulses.
module tb_div16x8;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic        start_in;
    logic        signed_in;
    logic [15:0] dividend_in;
    logic [7:0]  divisor_in;
    logic        busy_out;
    logic        done_out;
    logic        dz_out;
    logic [7:0]  q_out;
    logic [7:0]  r_out;
    logic [3:0]  ccr_out;

    div16x8 dut (
        .clk_in      (clk_in),
        .reset_n_in  (reset_n_in),
        .start_in    (start_in),
        .signed_in   (signed_in),
        .dividend_in (dividend_in),
        .divisor_in  (divisor_in),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .dz_out      (dz_out),
        .q_out       (q_out),
        .r_out       (r_out),
        .ccr_out     (ccr_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic [3:0] ccr;
        logic       dz;
        int         exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one line per completed transaction
    always @(negedge clk_in) begin
        if (done_out) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                $display("txn done cyc=%0d q=%02h r=%02h ccr=%01h dz=%0b", cyc, q_out, r_out, ccr_out, dz_out);
                chk("q", int'(q_out), int'(e.q));
                chk("r", int'(r_out), int'(e.r));
                chk("ccr", int'(ccr_out), int'(e.ccr));
                chk("dz", int'(dz_out), int'(e.dz));
                chk("busy_on_done", int'(busy_out), 0);
                chk("latency", cyc, e.exp_cyc);
            end
        end
    end

    // Issue at a negedge, wait (bounded) for done; returns on the done cycle so the
    // next call starts on that same cycle.
    task automatic run_op(input logic sgn, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] q, input logic [7:0] r, input logic [3:0] ccr,
                          input logic dz, input int lat, input int inj);
        exp_t e;
        bit   got;
        signed_in   = sgn;
        dividend_in = dvd;
        divisor_in  = dvs;
        start_in    = 1'b1;
        e.q = q; e.r = r; e.ccr = ccr; e.dz = dz;
        e.exp_cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk_in);
        start_in    = 1'b0;
        dividend_in = 16'hDEAD;
        divisor_in  = 8'h5A;
        chk("busy_after_accept", int'(busy_out), 1);
        got = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done_out) begin
                got = 1;
                break;
            end
            start_in = (i == inj);
            if (i == inj) begin
                signed_in   = ~sgn;
                dividend_in = 16'h00FF;
                divisor_in  = 8'h01;
            end
            @(negedge clk_in);
        end
        start_in = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done within 40 cycles, expected done after %0d", lat);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy_out), 0);
        chk({tag, "_done"}, int'(done_out), 0);
        chk({tag, "_dz"},   int'(dz_out), 0);
        chk({tag, "_q"},    int'(q_out), 0);
        chk({tag, "_r"},    int'(r_out), 0);
        chk({tag, "_ccr"},  int'(ccr_out), 0);
    endtask

    initial begin
        int dc;
        reset_n_in  = 1'b0;
        start_in    = 1'b0;
        signed_in   = 1'b0;
        dividend_in = '0;
        divisor_in  = '0;
        repeat (3) @(negedge clk_in);
        chk_all_zero("reset");
        reset_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        //      sgn   dividend  dvs    q      r      ccr   dz  lat inj
        run_op(1'b0, 16'h03E8, 8'h07, 8'h8E, 8'h06, 4'h8, 0, 17, 0);  // 1000/7
        run_op(1'b1, 16'hFE0C, 8'h07, 8'hB9, 8'hFD, 4'h9, 0, 17, 0);  // -500/7
        run_op(1'b1, 16'h01F4, 8'hF9, 8'hB9, 8'h03, 4'h9, 0, 17, 0);  // 500/-7
        run_op(1'b0, 16'h03E8, 8'h07, 8'h8E, 8'h06, 4'h8, 0, 17, 0);
        run_op(1'b0, 16'h1234, 8'h00, 8'h8E, 8'h06, 4'h8, 1, 1,  0);  // divide by zero
        run_op(1'b0, 16'h1000, 8'h01, 8'h00, 8'h00, 4'h6, 0, 17, 0);  // unsigned overflow
        run_op(1'b1, 16'h8000, 8'h80, 8'h00, 8'h00, 4'h6, 0, 17, 0);  // -32768/-128
        run_op(1'b1, 16'h8000, 8'h01, 8'h00, 8'h00, 4'h6, 0, 17, 0);  // -32768/1
        run_op(1'b0, 16'hFFFF, 8'hFF, 8'h01, 8'h00, 4'h3, 0, 17, 0);  // 257 -> V
        run_op(1'b0, 16'h00FF, 8'h10, 8'h0F, 8'h0F, 4'h1, 0, 17, 0);
        run_op(1'b1, 16'hFFFF, 8'h01, 8'hFF, 8'h00, 4'h9, 0, 17, 0);  // -1/1
        run_op(1'b1, 16'hFFF9, 8'h02, 8'hFD, 8'hFF, 4'h9, 0, 17, 0);  // -7/2
        run_op(1'b1, 16'hFF80, 8'h01, 8'h80, 8'h00, 4'h8, 0, 17, 0);  // -128 fits
        run_op(1'b0, 16'h03E8, 8'h07, 8'h8E, 8'h06, 4'h8, 0, 17, 5);  // ignored restart at E5
        run_op(1'b1, 16'h0080, 8'h01, 8'h80, 8'h00, 4'hA, 0, 17, 0);  // +128 overflows

        // Reset in the middle of an operation: abandoned, no done pulse
        signed_in   = 1'b0;
        dividend_in = 16'h03E8;
        divisor_in  = 8'h07;
        start_in    = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        chk("busy_before_reset", int'(busy_out), 1);
        repeat (7) @(negedge clk_in);
        reset_n_in = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk_in);
        reset_n_in = 1'b1;
        dc = done_cnt;
        repeat (30) @(negedge clk_in);
        chk("no_done_after_reset", done_cnt, dc);
        chk("idle_after_reset", int'(busy_out), 0);

        run_op(1'b0, 16'h03E8, 8'h07, 8'h8E, 8'h06, 4'h8, 0, 17, 0);
        repeat (3) @(negedge clk_in);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion within 20000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
